// File: rtl/pipe_fwd_regs_pkg.sv
// pipe_fwd_regs_pkg
//   Constants shared by the pipeline-register/forwarding block and the
//   hazard detection unit: datapath width, hazard optype encodings and
//   operand forward-select codes. Both blocks must agree on these values.
package pipe_fwd_regs_pkg;

    localparam int XLEN = 32;

    // Hazard optype of the instruction occupying a stage.
    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_ALU   = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;
    localparam logic [1:0] OP_STORE = 2'd3;

    // Operand source select driven by the hazard unit.
    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_EXE  = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;
    localparam logic [1:0] FWD_LOAD = 2'd3;

    // Instructions that write the register file (and can act as forwarding
    // sources). Bubbles and stores never do.
    function automatic logic op_writes_rd(input logic [1:0] op);
        return (op == OP_ALU) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/pipe_fwd_regs_fwd_mux4.sv
// fwd_mux4
//   4:1 operand mux selecting between register-file data and the three
//   forwarding sources.
//   Ports:
//     sel      in  2     FWD_RF / FWD_EXE / FWD_MEM / FWD_LOAD
//     in_rf    in  XLEN  register-file read data
//     in_exe   in  XLEN  ALU result of the instruction in EXE
//     in_mem   in  XLEN  registered ALU result of the instruction in MEM
//     in_load  in  XLEN  load data of the instruction in MEM
//     out      out XLEN  selected operand
module fwd_mux4
    import pipe_fwd_regs_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] in_rf,
    input  logic [W-1:0] in_exe,
    input  logic [W-1:0] in_mem,
    input  logic [W-1:0] in_load,
    output logic [W-1:0] out
);

    always_comb begin
        out = in_rf;
        case (sel)
            FWD_RF:   out = in_rf;
            FWD_EXE:  out = in_exe;
            FWD_MEM:  out = in_mem;
            FWD_LOAD: out = in_load;
            default:  out = in_rf;
        endcase
    end

endmodule

// File: rtl/pipe_fwd_regs.sv
// pipe_fwd_regs
//   ID/EX, EX/MEM and MEM/WB pipeline registers plus operand forwarding for
//   the 5-stage RV32 core. Applies the hazard unit's enable/flush controls,
//   resolves forward selects into operand values and publishes the per-stage
//   rd/rs2/optype values the hazard unit compares against.
//
//   Ports:
//     clk, rst                 clock, synchronous active-low reset
//     rd_ID, rs2_ID            ID destination / rs2 index
//     hazard_optype_ID         ID optype (NONE/ALU/LOAD/STORE)
//     rs1_data_ID, rs2_data_ID register-file read data
//     forward_ctrl_A/B         operand forward selects
//     forward_ctrl_ls          load-to-store data forward select
//     reg_DE_EN/flush          ID/EX controls
//     reg_EM_EN/flush          EX/MEM controls
//     reg_MW_EN                MEM/WB enable
//     alu_res_EXE              combinational ALU result in EXE
//     load_data_MEM            combinational load data in MEM
//     rd_EXE/MEM/WB, rs2_EXE   per-stage indices
//     hazard_optype_EXE/MEM    sanitized per-stage optype
//     rs1_val_EXE, rs2_val_EXE forwarded operands
//     alu_res_MEM              registered ALU result
//     store_data_MEM           store write data
//     wb_en_WB, wb_data_WB     register-file write port
//
//   Optional feature (macro PIPE_PERF_CNT_EN):
//     stall_cnt_o   saturating count of cycles with reg_DE_flush=1
//     retire_cnt_o  saturating count of cycles with a write-back or a
//                   STORE in MEM
module pipe_fwd_regs
    import pipe_fwd_regs_pkg::*;
#(
    parameter int DW    = pipe_fwd_regs_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    rd_ID,
    input  logic [4:0]    rs2_ID,
    input  logic [1:0]    hazard_optype_ID,
    input  logic [DW-1:0] rs1_data_ID,
    input  logic [DW-1:0] rs2_data_ID,
    input  logic [1:0]    forward_ctrl_A,
    input  logic [1:0]    forward_ctrl_B,
    input  logic          forward_ctrl_ls,
    input  logic          reg_DE_EN,
    input  logic          reg_DE_flush,
    input  logic          reg_EM_EN,
    input  logic          reg_EM_flush,
    input  logic          reg_MW_EN,
    input  logic [DW-1:0] alu_res_EXE,
    input  logic [DW-1:0] load_data_MEM,
    output logic [4:0]    rd_EXE,
    output logic [4:0]    rd_MEM,
    output logic [4:0]    rd_WB,
    output logic [4:0]    rs2_EXE,
    output logic [1:0]    hazard_optype_EXE,
    output logic [1:0]    hazard_optype_MEM,
    output logic [DW-1:0] rs1_val_EXE,
    output logic [DW-1:0] rs2_val_EXE,
    output logic [DW-1:0] alu_res_MEM,
    output logic [DW-1:0] store_data_MEM,
    output logic          wb_en_WB,
`ifdef PIPE_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o,
`endif
    output logic [DW-1:0] wb_data_WB
);

    localparam int NUM_OPND = 2;  // index 0 = A/rs1, 1 = B/rs2

    // ---------------- operand select (ID) ----------------
    logic [NUM_OPND-1:0][1:0]    fwd_sel;
    logic [NUM_OPND-1:0][DW-1:0] rf_data;
    logic [NUM_OPND-1:0][DW-1:0] opnd_id;

    // ---------------- stage registers ----------------
    logic [4:0]                  rd_exe_q,  rd_exe_d;
    logic [4:0]                  rs2_exe_q, rs2_exe_d;
    logic [1:0]                  op_exe_q,  op_exe_d;
    logic [NUM_OPND-1:0][DW-1:0] opnd_exe_q, opnd_exe_d;

    logic [4:0]                  rd_mem_q,  rd_mem_d;
    logic [1:0]                  op_mem_q,  op_mem_d;
    logic [DW-1:0]               alu_mem_q, alu_mem_d;
    logic [DW-1:0]               st_mem_q,  st_mem_d;

    logic [4:0]                  rd_wb_q,   rd_wb_d;
    logic                        wben_wb_q, wben_wb_d;
    logic [DW-1:0]               wbd_wb_q,  wbd_wb_d;

    logic [1:0]                  op_id_san;

    assign fwd_sel = {forward_ctrl_B, forward_ctrl_A};
    assign rf_data = {rs2_data_ID, rs1_data_ID};

    // MEM-stage forwarding uses the registered ALU result already held here.
    for (genvar g = 0; g < NUM_OPND; g++) begin : g_opnd
        fwd_mux4 #(.W(DW)) u_fwd (
            .sel     (fwd_sel[g]),
            .in_rf   (rf_data[g]),
            .in_exe  (alu_res_EXE),
            .in_mem  (alu_mem_q),
            .in_load (load_data_MEM),
            .out     (opnd_id[g])
        );
    end

    // A write to x0 is demoted to a bubble so it can never be selected as a
    // forwarding source nor written back. Stores have no rd and pass as-is.
    always_comb begin
        op_id_san = hazard_optype_ID;
        if (rd_ID == 5'd0 && op_writes_rd(hazard_optype_ID))
            op_id_san = OP_NONE;
    end

    // ID/EX: flush beats hold, hold beats load.
    always_comb begin
        rd_exe_d   = rd_exe_q;
        rs2_exe_d  = rs2_exe_q;
        op_exe_d   = op_exe_q;
        opnd_exe_d = opnd_exe_q;
        if (reg_DE_flush) begin
            rd_exe_d   = '0;
            rs2_exe_d  = '0;
            op_exe_d   = OP_NONE;
            opnd_exe_d = '0;
        end else if (reg_DE_EN) begin
            rd_exe_d   = rd_ID;
            rs2_exe_d  = rs2_ID;
            op_exe_d   = op_id_san;
            opnd_exe_d = opnd_id;
        end
    end

    // EX/MEM: same priority. Store data may come from a load that is in MEM
    // right now (load immediately followed by a dependent store).
    always_comb begin
        rd_mem_d  = rd_mem_q;
        op_mem_d  = op_mem_q;
        alu_mem_d = alu_mem_q;
        st_mem_d  = st_mem_q;
        if (reg_EM_flush) begin
            rd_mem_d  = '0;
            op_mem_d  = OP_NONE;
            alu_mem_d = '0;
            st_mem_d  = '0;
        end else if (reg_EM_EN) begin
            rd_mem_d  = rd_exe_q;
            op_mem_d  = op_exe_q;
            alu_mem_d = alu_res_EXE;
            st_mem_d  = forward_ctrl_ls ? load_data_MEM : opnd_exe_q[1];
        end
    end

    // MEM/WB: no flush, only hold.
    always_comb begin
        rd_wb_d   = rd_wb_q;
        wben_wb_d = wben_wb_q;
        wbd_wb_d  = wbd_wb_q;
        if (reg_MW_EN) begin
            rd_wb_d   = rd_mem_q;
            wben_wb_d = op_writes_rd(op_mem_q);
            wbd_wb_d  = (op_mem_q == OP_LOAD) ? load_data_MEM : alu_mem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_exe_q   <= '0;
            rs2_exe_q  <= '0;
            op_exe_q   <= OP_NONE;
            opnd_exe_q <= '0;
            rd_mem_q   <= '0;
            op_mem_q   <= OP_NONE;
            alu_mem_q  <= '0;
            st_mem_q   <= '0;
            rd_wb_q    <= '0;
            wben_wb_q  <= 1'b0;
            wbd_wb_q   <= '0;
        end else begin
            rd_exe_q   <= rd_exe_d;
            rs2_exe_q  <= rs2_exe_d;
            op_exe_q   <= op_exe_d;
            opnd_exe_q <= opnd_exe_d;
            rd_mem_q   <= rd_mem_d;
            op_mem_q   <= op_mem_d;
            alu_mem_q  <= alu_mem_d;
            st_mem_q   <= st_mem_d;
            rd_wb_q    <= rd_wb_d;
            wben_wb_q  <= wben_wb_d;
            wbd_wb_q   <= wbd_wb_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (reg_DE_flush && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if ((wben_wb_q || op_mem_q == OP_STORE) && retire_cnt_q != '1)
            retire_cnt_d = retire_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign retire_cnt_o = retire_cnt_q;
`endif

    assign rd_EXE            = rd_exe_q;
    assign rs2_EXE           = rs2_exe_q;
    assign hazard_optype_EXE = op_exe_q;
    assign rs1_val_EXE       = opnd_exe_q[0];
    assign rs2_val_EXE       = opnd_exe_q[1];
    assign rd_MEM            = rd_mem_q;
    assign hazard_optype_MEM = op_mem_q;
    assign alu_res_MEM       = alu_mem_q;
    assign store_data_MEM    = st_mem_q;
    assign rd_WB             = rd_wb_q;
    assign wb_en_WB          = wben_wb_q;
    assign wb_data_WB        = wbd_wb_q;

endmodule
